// File: rtl/regfile_pkg.sv
// Shared constants and types for the sweeping register file.
package regfile_pkg;

    localparam int REGFILE_WIDTH  = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DEPTH  = 32;

    // Register 0 is hardwired to zero: never written, always reads 0.
    localparam int ZERO_REG = 0;

    typedef enum logic [0:0] {
        SWEEP_IDLE   = 1'b0,
        SWEEP_ACTIVE = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/regfile_sweep_if.sv
// Bus bundle between the datapath (master) and the register file (slave).
interface regfile_sweep_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] WriteRegister;
    logic              RegWrite;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              Clear;
    logic              Busy;
    logic              WriteDropped;

    modport master (
        output WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, Clear,
        input  ReadData1, ReadData2, Busy, WriteDropped
    );

    modport slave (
        input  WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, Clear,
        output ReadData1, ReadData2, Busy, WriteDropped
    );
endinterface

// File: rtl/regfile_sweep_decoder.sv
// One-hot write-address decoder; register 0 can never be selected.
module regfile_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W,
    localparam int DEPTH = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [DEPTH-1:0]  sel
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            if (gi == ZERO_REG) begin : g_zero
                assign sel[gi] = 1'b0;
            end else begin : g_addr
                assign sel[gi] = en && (addr == ADDR_W'(gi));
            end
        end
    endgenerate

endmodule

// File: rtl/regfile_sweep.sv
// 32x32 register file with two combinational read ports, one write port,
// register 0 hardwired to zero and a sequential clear sweep (regs 1..DEPTH-1,
// one per cycle) that blocks writes while it runs.
// Optional build macro: REGFILE_WRITE_BYPASS_EN adds same-cycle write-through
// forwarding to both read ports.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic           Clk,
    input  logic           Reset_n,
    regfile_sweep_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [0:0]        ST_IDLE   = SWEEP_IDLE;
    localparam logic [0:0]        ST_ACTIVE = SWEEP_ACTIVE;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              idle;
    logic              write_en;
    logic [DEPTH-1:0]  wr_sel;
    logic [DEPTH-1:0]  sweep_sel;
    logic [WIDTH-1:0]  reg_q [DEPTH];
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    assign idle     = (state_reg == ST_IDLE);
    // Writes are only honoured while no sweep is running.
    assign write_en = bus.RegWrite && idle;

    regfile_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .addr (bus.WriteRegister),
        .en   (write_en),
        .sel  (wr_sel)
    );

    // Sweep FSM: pointer walks 1..DEPTH-1 and rests at 1 when idle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= PTR_FIRST;
        end else if (idle) begin
            if (bus.Clear) begin
                state_reg <= ST_ACTIVE;
                ptr_reg   <= PTR_FIRST;
            end
        end else if (ptr_reg == PTR_LAST) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= PTR_FIRST;
        end else begin
            ptr_reg <= ptr_reg + ADDR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign sweep_sel[gi] = 1'b0;
                assign reg_q[gi]     = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q_reg;

                // The sweep select is only live outside IDLE, where the
                // decoder is disabled, so the two never collide.
                assign sweep_sel[gi] = !idle && (ptr_reg == ADDR_W'(gi));

                // Per-register storage: sweep zeroes it, decoder loads it.
                always_ff @(posedge Clk or negedge Reset_n) begin
                    if (!Reset_n) begin
                        q_reg <= '0;
                    end else if (sweep_sel[gi]) begin
                        q_reg <= '0;
                    end else if (wr_sel[gi]) begin
                        q_reg <= bus.WriteData;
                    end
                end

                assign reg_q[gi] = q_reg;
            end
        end
    endgenerate

    // Read port 1: stored value, optionally forwarded from the write port.
    always_comb begin
        rd1 = reg_q[bus.ReadRegister1];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_en && (bus.WriteRegister != ZERO_ADDR) &&
            (bus.WriteRegister == bus.ReadRegister1)) begin
            rd1 = bus.WriteData;
        end
`endif
    end

    // Read port 2: stored value, optionally forwarded from the write port.
    always_comb begin
        rd2 = reg_q[bus.ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_en && (bus.WriteRegister != ZERO_ADDR) &&
            (bus.WriteRegister == bus.ReadRegister2)) begin
            rd2 = bus.WriteData;
        end
`endif
    end

    assign bus.ReadData1    = rd1;
    assign bus.ReadData2    = rd2;
    assign bus.Busy         = !idle;
    // Any write attempt during a sweep, including to register 0, is reported.
    assign bus.WriteDropped = bus.RegWrite && !idle;

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: directed scenarios with literal
// expectations plus randomized traffic against an array-based model.
module tb_regfile_sweep;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_sweep_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

    regfile_sweep #(.WIDTH(W), .ADDR_W(AW)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Model: register contents plus "next register the sweep clears" (0 = idle).
    logic [W-1:0] m_regs [D];
    int           m_next = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) m_regs[i] = '0;
            m_next = 0;
        end else if (m_next == 0) begin
            if (bus.RegWrite && bus.WriteRegister != 0)
                m_regs[bus.WriteRegister] = bus.WriteData;
            if (bus.Clear) m_next = 1;
        end else begin
            m_regs[m_next] = '0;
            m_next = (m_next == D - 1) ? 0 : m_next + 1;
        end
    end

    function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = (a == 0) ? '0 : m_regs[a];
        if (BYPASS && bus.RegWrite && m_next == 0 && a != 0 && bus.WriteRegister == a)
            v = bus.WriteData;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rd1",  bus.ReadData1, exp_read(bus.ReadRegister1));
            check("cyc_rd2",  bus.ReadData2, exp_read(bus.ReadRegister2));
            check("cyc_busy", W'(bus.Busy), W'(m_next != 0));
            check("cyc_drop", W'(bus.WriteDropped), W'(bus.RegWrite && m_next != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.RegWrite = 1'b1;
        bus.WriteRegister = a;
        bus.WriteData = d;
        $display("txn write reg=%0d data=%0d busy=%0b", a, d, bus.Busy);
        tick();
        bus.RegWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.WriteData = '0; bus.WriteRegister = '0; bus.RegWrite = 1'b0;
        bus.ReadRegister1 = '0; bus.ReadRegister2 = '0; bus.Clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", W'(bus.Busy), 0);
        check("reset_drop", W'(bus.WriteDropped), 0);
        bus.ReadRegister1 = 5'd5;
        #1 check("reset_reg5", bus.ReadData1, 0);
        tick();
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Write enable low: nothing stored.
        bus.RegWrite = 1'b0; bus.WriteData = 42; bus.WriteRegister = 2; bus.ReadRegister1 = 2;
        $display("txn idle-write reg=2 data=42 RegWrite=0");
        tick();
        check("we_ignored", bus.ReadData1, 0);

        // Decoder isolation.
        wr(5'd31, 10);
        bus.ReadRegister1 = 8;  #1 check("dec_reg8", bus.ReadData1, 0);
        bus.ReadRegister1 = 31; #1 check("dec_reg31", bus.ReadData1, 10);

        // Register zero.
        bus.ReadRegister1 = 0; bus.RegWrite = 1'b1; bus.WriteRegister = 0; bus.WriteData = 404;
        #1 check("zero_drop", W'(bus.WriteDropped), 0);
        check("zero_pre", bus.ReadData1, 0);
        $display("txn write reg=0 data=404");
        tick();
        bus.RegWrite = 1'b0;
        #1 check("zero_post", bus.ReadData1, 0);

        // Port 2 addressing.
        wr(5'd10, 713);
        wr(5'd17, 99);
        bus.ReadRegister2 = 10; #1 check("p2_reg10", bus.ReadData2, 713);
        bus.ReadRegister2 = 17; #1 check("p2_reg17", bus.ReadData2, 99);

        // Sweep over a preloaded file.
        for (int i = 1; i < D; i++) wr(AW'(i), W'(i));
        bus.Clear = 1'b1;
        $display("txn clear");
        tick();
        bus.Clear = 1'b0;
        cnt = 0;
        while (bus.Busy && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                bus.ReadRegister1 = 3; bus.ReadRegister2 = 20;
                #1 check("sw5_reg3", bus.ReadData1, 0);
                check("sw5_reg20", bus.ReadData2, 20);
            end
            if (cnt == 7) begin
                bus.RegWrite = 1'b1; bus.WriteRegister = 20; bus.WriteData = 55;
                $display("txn write reg=20 data=55 during sweep");
                #1 check("sw_drop_hi", W'(bus.WriteDropped), 1);
            end
            if (cnt == 8) begin
                bus.RegWrite = 1'b0;
                #1 check("sw_drop_lo", W'(bus.WriteDropped), 0);
            end
            if (cnt == 12) begin bus.Clear = 1'b1; $display("txn clear during sweep"); end
            if (cnt == 13) bus.Clear = 1'b0;
            tick();
        end
        check("sweep_len", W'(cnt), 31);
        check("sweep_done", W'(bus.Busy), 0);
        for (int a = 0; a < D; a++) begin
            bus.ReadRegister1 = AW'(a);
            #1 check("post_sweep_zero", bus.ReadData1, 0);
        end

        // Reset in the middle of a sweep.
        wr(5'd9, 123);
        bus.Clear = 1'b1;
        $display("txn clear");
        tick();
        bus.Clear = 1'b0;
        repeat (9) tick();
        check("rst_pre_busy", W'(bus.Busy), 1);
        rst_n = 1'b0;
        $display("txn reset mid-sweep");
        #1 check("rst_busy", W'(bus.Busy), 0);
        for (int a = 0; a < D; a++) begin
            bus.ReadRegister2 = AW'(a);
            #1 check("rst_zero", bus.ReadData2, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        bus.ReadRegister1 = 4; bus.RegWrite = 1'b1; bus.WriteRegister = 4; bus.WriteData = 7;
        #1 check("bypass_reg4", bus.ReadData1, BYPASS ? 7 : 0);
        $display("txn write reg=4 data=7");
        tick();
        bus.RegWrite = 1'b0;
        #1 check("after_rst_reg4", bus.ReadData1, 7);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 800; c++) begin
            bus.RegWrite      = ($urandom_range(0, 1) == 1);
            bus.WriteRegister = AW'($urandom_range(0, D - 1));
            bus.WriteData     = W'($urandom);
            bus.ReadRegister1 = AW'($urandom_range(0, D - 1));
            bus.ReadRegister2 = ($urandom_range(0, 3) == 0) ? bus.WriteRegister
                                                              : AW'($urandom_range(0, D - 1));
            bus.Clear         = ($urandom_range(0, 59) == 0);
            if (bus.RegWrite || bus.Clear)
                $display("txn rand we=%0b reg=%0d data=%0d clear=%0b busy=%0b",
                         bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Clear, bus.Busy);
            tick();
        end
        bus.RegWrite = 1'b0;
        bus.Clear = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
